// File: rtl/data_mem_resp.sv
// Word-addressed data memory with an in-order response queue, minimum response
// latency, load-linked/store-conditional link bit and out-of-range faults.
module data_mem_resp #(
  parameter int GRLEN  = 32,
  parameter int IDX_W  = 10,
  parameter int QDEPTH = 4,
  parameter int LAT    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_req,
  input  logic [GRLEN-1:0] data_addr,
  input  logic             data_wr,
  input  logic [3:0]       data_wstrb,
  input  logic [GRLEN-1:0] data_wdata,
  input  logic             data_prefetch,
  input  logic             data_ll,
  input  logic             data_sc,
  input  logic             data_cancel,
  input  logic             data_recv,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [GRLEN-1:0] data_rdata,
  output logic             data_scsucceed,
  output logic             data_exception,
  output logic [5:0]       data_excode,
  output logic [GRLEN-1:0] data_badvaddr,
  output logic             data_req_empty
);

  localparam int             PW        = $clog2(QDEPTH);
  localparam int             MEM_WORDS = 1 << IDX_W;
  localparam logic [PW:0]    DEPTH_C   = (PW+1)'(QDEPTH);
  localparam logic [2:0]     LAT_C     = 3'(LAT);
  localparam logic [5:0]     EXC_ADE   = 6'h08;

  logic [GRLEN-1:0] r_mem     [MEM_WORDS];
  logic [GRLEN-1:0] r_q_rdata [QDEPTH];
  logic [GRLEN-1:0] r_q_bad   [QDEPTH];
  logic             r_q_sc    [QDEPTH];
  logic             r_q_exc   [QDEPTH];
  logic [2:0]       r_q_age   [QDEPTH];

  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [PW:0]      r_count;
  logic             r_llbit;
  logic [IDX_W-1:0] r_ll_idx;

  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_push;
  logic             w_pop;
  logic             w_access;
  logic             w_store;
  logic             w_do_write;
  logic [GRLEN-1:0] w_resp_rdata;
  logic             w_resp_exc;
  logic             w_resp_sc;

  assign w_idx    = data_addr[IDX_W+1:2];
  // Any address bit at or above the array's byte span marks a fault.
  assign w_oor    = (data_addr >> (IDX_W + 2)) != '0;
  assign w_push   = data_req & data_addr_ok;
  assign w_pop    = data_data_ok & data_recv;
  assign w_access = w_push & ~data_prefetch & ~w_oor;
  assign w_store  = w_access & data_wr;
  assign w_do_write = w_store & (~data_sc | r_llbit);

  assign w_resp_rdata = (w_access & ~data_wr) ? r_mem[w_idx] : '0;
  assign w_resp_exc   = w_oor & ~data_prefetch;
  assign w_resp_sc    = w_store & data_sc & r_llbit;

  // NOTE: storage arrays carry no reset; only the control state that decides
  // validity is reset, so array contents survive a reset and cost no reset tree.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wstrb[b]) r_mem[w_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end
    end
    if (w_push) begin
      r_q_rdata[r_wptr] <= w_resp_rdata;
      r_q_sc[r_wptr]    <= w_resp_sc;
      r_q_exc[r_wptr]   <= w_resp_exc;
      r_q_bad[r_wptr]   <= w_resp_exc ? data_addr : '0;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; a later assignment in the block wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_count  <= '0;
      r_llbit  <= 1'b0;
      r_ll_idx <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q_age[i] <= 3'd0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (r_q_age[i] < LAT_C) r_q_age[i] <= r_q_age[i] + 3'd1;
      end

      if (data_cancel) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr          <= r_wptr + 1'b1;
          r_q_age[r_wptr] <= 3'd1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      // Link bit follows accepted in-range, non-prefetch accesses only.
      if (w_access) begin
        if (!data_wr && data_ll) begin
          r_llbit  <= 1'b1;
          r_ll_idx <= w_idx;
        end else if (data_wr && data_sc) begin
          r_llbit <= 1'b0;
        end else if (data_wr && (w_idx == r_ll_idx)) begin
          r_llbit <= 1'b0;
        end
      end
    end
  end

  assign data_addr_ok   = ~reset & ~data_cancel & (r_count < DEPTH_C);
  assign data_data_ok   = (r_count != '0) && (r_q_age[r_rptr] >= LAT_C);
  assign data_req_empty = (r_count == '0);

  assign data_rdata     = data_data_ok ? r_q_rdata[r_rptr] : '0;
  assign data_scsucceed = data_data_ok & r_q_sc[r_rptr];
  assign data_exception = data_data_ok & r_q_exc[r_rptr];
  assign data_excode    = (data_data_ok && r_q_exc[r_rptr]) ? EXC_ADE : 6'd0;
  assign data_badvaddr  = data_data_ok ? r_q_bad[r_rptr] : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: expected responses are queued at
// acceptance and compared against the head response every cycle it is valid.
module tb_data_mem_resp;
  localparam int LAT    = 2;
  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr, data_prefetch, data_ll, data_sc, data_cancel, data_recv;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok, data_scsucceed, data_exception, data_req_empty;
  logic [31:0] data_rdata, data_badvaddr;
  logic [5:0]  data_excode;

  data_mem_resp #(.GRLEN(32), .IDX_W(10), .QDEPTH(QDEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .data_req(data_req), .data_addr(data_addr),
    .data_wr(data_wr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_prefetch(data_prefetch), .data_ll(data_ll), .data_sc(data_sc),
    .data_cancel(data_cancel), .data_recv(data_recv), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .data_scsucceed(data_scsucceed),
    .data_exception(data_exception), .data_excode(data_excode),
    .data_badvaddr(data_badvaddr), .data_req_empty(data_req_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        sc;
    logic        exc;
    logic [31:0] bad;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int];
  bit          m_llbit = 1'b0;
  int          m_ll_idx = -1;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rand_recv = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Head-of-queue monitor: checks every valid cycle, pops on handshake.
  always @(negedge clk) begin
    if (!reset && data_data_ok) begin
      if (sb.size() == 0) begin
        check("spurious_data_ok", data_data_ok, 1'b0);
      end else begin
        check("rdata", data_rdata, sb[0].rdata);
        check("scsucceed", data_scsucceed, sb[0].sc);
        check("exception", data_exception, sb[0].exc);
        check("excode", data_excode, sb[0].exc ? 6'h08 : 6'h00);
        check("badvaddr", data_badvaddr, sb[0].bad);
        check("lat_min", (cyc - sb[0].acc) >= LAT, 1'b1);
        if (data_recv) begin
          if (sb[0].chk_lat) check("lat_exact", cyc - sb[0].acc, LAT);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_recv) data_recv = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of one accepted request; updates memory/link model.
  function automatic void model_accept(input bit wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       input bit ll, input bit sc, input bit pf,
                                       input bit chk_lat);
    exp_t        e;
    int          idx;
    logic [31:0] w;
    idx = int'(addr[11:2]);
    e.rdata = '0; e.sc = 1'b0; e.exc = 1'b0; e.bad = '0;
    e.acc = cyc; e.chk_lat = chk_lat;
    if (pf) begin
      // no effect
    end else if (addr >= 32'h1000) begin
      e.exc = 1'b1;
      e.bad = addr;
    end else if (wr) begin
      if (!sc || m_llbit) begin
        w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        model_mem[idx] = w;
      end
      if (sc) begin
        e.sc = m_llbit;
        m_llbit = 1'b0;
      end else if (idx == m_ll_idx) begin
        m_llbit = 1'b0;
      end
    end else begin
      e.rdata = model_mem[idx];
      if (ll) begin
        m_llbit = 1'b1;
        m_ll_idx = idx;
      end
    end
    sb.push_back(e);
  endfunction

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit ll, input bit sc, input bit pf,
                       input bit chk_lat);
    int n = 0;
    data_req = 1'b1; data_addr = addr; data_wr = wr; data_wdata = wdata;
    data_wstrb = strb; data_ll = ll; data_sc = sc; data_prefetch = pf;
    @(negedge clk);
    while (!data_addr_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", n < 200, 1'b1);
    if (n < 200) model_accept(wr, addr, wdata, strb, ll, sc, pf, chk_lat);
    @(posedge clk); #1;
    data_req = 1'b0; data_wr = 1'b0; data_ll = 1'b0; data_sc = 1'b0; data_prefetch = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input bit chk_lat);
    issue(1'b0, addr, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, chk_lat);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    issue(1'b1, addr, wdata, strb, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", sb.size(), 0);
    check("empty_after_drain", data_req_empty, 1'b1);
  endtask

  initial begin
    reset = 1'b1; data_req = 1'b0; data_addr = '0; data_wr = 1'b0; data_wstrb = '0;
    data_wdata = '0; data_prefetch = 1'b0; data_ll = 1'b0; data_sc = 1'b0;
    data_cancel = 1'b0; data_recv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", data_addr_ok, 1'b0);
    check("rst_data_ok", data_data_ok, 1'b0);
    check("rst_empty", data_req_empty, 1'b1);
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_exc", {data_exception, data_excode, data_scsucceed}, 8'h0);
    check("rst_bad", data_badvaddr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("addr_ok_after_reset", data_addr_ok, 1'b1);
    @(posedge clk); #1;

    // Full store then load, exact latency; then partial-lane store.
    data_recv = 1'b1;
    store(32'h40, 32'h12345678, 4'hF);
    load(32'h40, 1'b1);
    drain();
    store(32'h40, 32'hAABBCCDD, 4'b0101);
    load(32'h40, 1'b1);
    drain();

    // Link bit: ll/sc/sc, then ll/plain store/sc.
    store(32'h80, 32'h0, 4'hF);
    issue(1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h80, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 32'h80, 32'h22222222, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    load(32'h80, 1'b0);
    issue(1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    store(32'h80, 32'h33333333, 4'hF);
    issue(1'b1, 32'h80, 32'h44444444, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    load(32'h80, 1'b0);
    drain();

    // Faults and prefetches.
    load(32'h1000, 1'b0);
    issue(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    store(32'h1004, 32'hDEADBEEF, 4'hF);
    load(32'h40, 1'b0);
    drain();

    // Queue full: 5th request held off until one pop.
    data_recv = 1'b0;
    for (int i = 0; i < QDEPTH; i++) load((i % 2 == 0) ? 32'h40 : 32'h80, 1'b0);
    data_req = 1'b1; data_addr = 32'h80; data_wr = 1'b0;
    @(negedge clk);
    check("full_addr_ok", data_addr_ok, 1'b0);
    check("full_not_empty", data_req_empty, 1'b0);
    @(posedge clk); #1;
    data_recv = 1'b1;
    @(negedge clk);
    check("full_pop_addr_ok", data_addr_ok, 1'b0);
    check("full_head_ok", data_data_ok, 1'b1);
    @(posedge clk); #1;
    data_recv = 1'b0;
    @(negedge clk);
    check("reopen_addr_ok", data_addr_ok, 1'b1);
    if (data_addr_ok) model_accept(1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    data_req = 1'b0;
    data_recv = 1'b1;
    drain();

    // Random mix with random back-pressure.
    for (int i = 0; i < 16; i++) store(32'(i * 4), $urandom, 4'hF);
    rand_recv = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      case (op)
        0: load(a, 1'b0);
        1: issue(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b0);
        2: issue(1'b0, a, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        3: issue(1'b1, a, $urandom, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        4: issue(1'b0, a | 32'h3000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: load(a | 32'h1000, 1'b0);
      endcase
    end
    rand_recv = 1'b0;
    data_recv = 1'b1;
    drain();

    // Cancel with pending responses; the store already written must persist.
    data_recv = 1'b0;
    store(32'hC0, 32'h5A5AA5A5, 4'hF);
    load(32'h40, 1'b0);
    load(32'h80, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    data_req = 1'b1; data_addr = 32'h40; data_cancel = 1'b1;
    @(negedge clk);
    check("cancel_addr_ok", data_addr_ok, 1'b0);
    @(posedge clk); #1;
    data_cancel = 1'b0; data_req = 1'b0;
    sb.delete();
    check("cancel_empty", data_req_empty, 1'b1);
    check("cancel_data_ok", data_data_ok, 1'b0);
    data_recv = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    load(32'hC0, 1'b1);
    drain();

    // Reset mid-stream: drops responses and link bit, keeps the array.
    data_recv = 1'b0;
    issue(1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    load(32'h40, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_addr_ok", data_addr_ok, 1'b0);
    check("mid_rst_data_ok", data_data_ok, 1'b0);
    check("mid_rst_empty", data_req_empty, 1'b1);
    check("mid_rst_rdata", data_rdata, 32'h0);
    sb.delete();
    m_llbit = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_reopen", data_addr_ok, 1'b1);
    @(posedge clk); #1;
    data_recv = 1'b1;
    load(32'h40, 1'b1);
    issue(1'b1, 32'h80, 32'h77777777, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    load(32'h80, 1'b0);
    load(32'hC0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
